lvt_accounter: RTL and testbench
================================

# lvt_accounter

Parametrised live-value-table accounter for multi-port RAMs built from per-write-agent banks. It tracks which write agent last updated each row and returns, per read agent, the bank select aligned with that agent's RAM read data. It adds configurable read latency, deterministic write-write collision arbitration, a selectable read-during-write mode, and a saturating collision counter. It sits beside the banked RAM array and drives the per-read-agent output muxes.

## Interface

- ADDR_WIDTH, 8, write/read address width
- RAM_DEPTH, 2**ADDR_WIDTH, number of tracked rows; addresses >= RAM_DEPTH ignored
- NB_WRAGENT, 2, number of write agents (>= 1)
- NB_RDAGENT, 2, number of read agents (>= 1)
- SELECT_WIDTH, NB_WRAGENT==1 ? 1 : $clog2(NB_WRAGENT), width of one select
- RD_LATENCY, 1, cycles from rden to rdselect/rdvalid, legal 1..4; must equal the bank RAM read latency
- COLLISION_POLICY, 0, 0: highest-index writer wins, 1: lowest-index writer wins
- RDW_MODE, 0, read-during-write to same row: 0 returns the old owner, 1 returns the new owner
- COUNT_WIDTH, 16, collision counter width

Ports:
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  asynchronous active-low reset
- wren  input  NB_WRAGENT  per-agent write enable
- wraddr  input  NB_WRAGENT*ADDR_WIDTH  per-agent write address, agent i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- rden  input  NB_RDAGENT  per-agent read enable
- rdaddr  input  NB_RDAGENT*ADDR_WIDTH  per-agent read address, same packing
- cnt_clear  input  1  synchronous clear of collision_count
- rdselect  output  NB_RDAGENT*SELECT_WIDTH  per-read-agent bank select
- rdvalid  output  NB_RDAGENT  per-read-agent select valid
- wrcollision  output  1  one-cycle pulse: two or more enabled writers hit the same row in the previous cycle
- collision_count  output  COUNT_WIDTH  saturating count of collision cycles

## Operation

- Table: RAM_DEPTH entries x SELECT_WIDTH flops; all entries reset to 0 (row owned by agent 0).
- Write: each cycle, for every row addressed by at least one enabled in-range writer, entry <= index of winning writer per COLLISION_POLICY. Distinct rows update independently in the same cycle.
- Collision: a cycle with two or more enabled writers on the same in-range row counts once, regardless of how many rows or agents collide. Next cycle wrcollision = 1; collision_count increments, holding at 2**COUNT_WIDTH-1.
- cnt_clear has priority over an increment in the same cycle: count becomes 0; wrcollision unaffected.
- Read: rden[j] samples rdaddr[j]. Entry value taken as pre-update table content (RDW_MODE 0) or, if any enabled writer hits that row the same cycle, the winning writer index (RDW_MODE 1).
- Read pipeline: select and valid pass through RD_LATENCY register stages per read agent; stages advance every cycle (no stall). rdvalid[j] = delayed rden[j]; rdselect[j] holds its last value when rdvalid[j] = 0.
- Out-of-range read address: rdvalid still asserted, rdselect = 0.
- NB_WRAGENT == 1: table constant 0; rdselect always 0; no collisions possible.

## Timing

- Reset (aresetn low, asynchronous): table 0, all pipeline stages 0, rdselect 0, rdvalid 0, wrcollision 0, collision_count 0. Reset mid-operation drops in-flight reads; no rdvalid after release for reads issued before reset.
- Write sampled at edge N is visible to a read sampled at edge N+1 (both modes); at edge N only in RDW_MODE 1.
- rden at edge N -> rdvalid/rdselect valid after edge N+RD_LATENCY; back-to-back reads every cycle supported.
- wrcollision asserted for exactly the cycle after the colliding write edge.

## Test plan

- Reset then read rows 0, 5, 255 from both read agents, RD_LATENCY=1 -> rdvalid one cycle later, rdselect = 0 for all.
- Agent 1 writes row 0x10 at edge N, agent 0 reads 0x10 at N+1 -> rdselect[0] = 1 at N+2; repeat with RD_LATENCY=3 -> valid at N+4.
- Agents 0 and 1 write row 0x20 same cycle -> table = 1 (policy 0) or 0 (policy 1); wrcollision pulses once; collision_count = 1.
- Agent 1 writes 0x30 while agent 0 reads 0x30 same edge, prior owner 0 -> rdselect 0 (RDW_MODE 0), 1 (RDW_MODE 1).
- COUNT_WIDTH=2, five collision cycles -> count 1,2,3,3,3; cnt_clear concurrent with a collision -> count 0.
- Assert aresetn low with reads in flight at RD_LATENCY=4 -> outputs 0 immediately, no rdvalid after release; table back to all 0.

Source files
------------

// File: rtl/lvt_accounter.sv
// lvt_accounter
//   Live-value table for a multi-port RAM built from one bank per write agent.
//   Records which write agent last wrote each row and, for every read agent,
//   delivers the bank select aligned with that agent's bank read data.
//   Also reports write-write collisions and keeps a saturating count of them.
//
// Ports
//   aclk            clock, rising edge
//   aresetn         asynchronous active-low reset
//   wren            per write agent enable
//   wraddr          per write agent row address, agent i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//   rden            per read agent enable
//   rdaddr          per read agent row address, same packing as wraddr
//   cnt_clear       synchronous clear of collision_count (wins over increment)
//   rdselect        per read agent bank select, SELECT_WIDTH bits each
//   rdvalid         per read agent select valid, rden delayed by RD_LATENCY
//   wrcollision     one-cycle pulse after a cycle with a same-row write collision
//   collision_count saturating number of collision cycles
module lvt_accounter #(
    parameter int ADDR_WIDTH       = 8,
    parameter int RAM_DEPTH        = 2**ADDR_WIDTH,
    parameter int NB_WRAGENT       = 2,
    parameter int NB_RDAGENT       = 2,
    parameter int SELECT_WIDTH     = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int RD_LATENCY       = 1,
    parameter int COLLISION_POLICY = 0,
    parameter int RDW_MODE         = 0,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NB_WRAGENT-1:0]              wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
    input  logic [NB_RDAGENT-1:0]              rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
    input  logic                               cnt_clear,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
    output logic [NB_RDAGENT-1:0]              rdvalid,
    output logic                               wrcollision,
    output logic [COUNT_WIDTH-1:0]             collision_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // ------------------------------------------------------------------
    // Address unpacking
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   wa [NB_WRAGENT];
    logic [ADDR_WIDTH-1:0]   ra [NB_RDAGENT];
    logic [NB_WRAGENT-1:0]   wact;

    always_comb begin
        wact = '0;
        for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
            wa[i]   = wraddr[ADDR_WIDTH*i +: ADDR_WIDTH];
            wact[i] = wren[i] && in_range(wa[i]);
        end
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            ra[j] = rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Write arbitration: at most one winner per row, so table writes from
    // different agents never target the same entry in one cycle.
    // ------------------------------------------------------------------
    logic [NB_WRAGENT-1:0] wwin;
    logic                  wcoll;

    always_comb begin
        wwin  = '0;
        wcoll = 1'b0;
        for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
            if (wact[i]) begin
                wwin[i] = 1'b1;
                for (int unsigned j = 0; j < NB_WRAGENT; j++) begin
                    if (j != i && wact[j] && wa[j] == wa[i]) begin
                        wcoll = 1'b1;
                        if (COLLISION_POLICY == 0) begin
                            if (j > i) wwin[i] = 1'b0;
                        end else begin
                            if (j < i) wwin[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Same-cycle write hit per read agent (used for new-owner bypass)
    // ------------------------------------------------------------------
    logic [NB_RDAGENT-1:0]   rdw_hit;
    logic [SELECT_WIDTH-1:0] rdw_sel [NB_RDAGENT];

    always_comb begin
        rdw_hit = '0;
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            rdw_sel[j] = '0;
            for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
                if (wwin[i] && wa[i] == ra[j]) begin
                    rdw_hit[j] = 1'b1;
                    rdw_sel[j] = SELECT_WIDTH'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Live-value table
    // ------------------------------------------------------------------
    logic [SELECT_WIDTH-1:0] tbl_rd [NB_RDAGENT];

    if (NB_WRAGENT > 1) begin : g_lvt
        logic [SELECT_WIDTH-1:0] lvt [RAM_DEPTH];

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                for (int unsigned r = 0; r < RAM_DEPTH; r++) begin
                    lvt[r] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
                    if (wwin[i]) begin
                        lvt[wa[i]] <= SELECT_WIDTH'(i);
                    end
                end
            end
        end

        always_comb begin
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                tbl_rd[j] = in_range(ra[j]) ? lvt[ra[j]] : '0;
            end
        end
    end else begin : g_single
        // With a single write agent every row is always owned by bank 0.
        always_comb begin
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                tbl_rd[j] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read lookup
    // ------------------------------------------------------------------
    logic [SELECT_WIDTH-1:0] rsel [NB_RDAGENT];

    always_comb begin
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            if (!in_range(ra[j])) begin
                rsel[j] = '0;
            end else if (RDW_MODE == 1 && rdw_hit[j]) begin
                rsel[j] = rdw_sel[j];
            end else begin
                rsel[j] = tbl_rd[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: each stage only loads its select when the valid
    // entering it is set, so the last stage holds the previous select
    // while rdvalid is low without any extra output register.
    // ------------------------------------------------------------------
    logic [NB_RDAGENT-1:0]   vld_pipe [RD_LATENCY];
    logic [SELECT_WIDTH-1:0] sel_pipe [RD_LATENCY][NB_RDAGENT];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned s = 0; s < RD_LATENCY; s++) begin
                vld_pipe[s] <= '0;
                for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                    sel_pipe[s][j] <= '0;
                end
            end
        end else begin
            vld_pipe[0] <= rden;
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                if (rden[j]) begin
                    sel_pipe[0][j] <= rsel[j];
                end
            end
            for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                    if (vld_pipe[s-1][j]) begin
                        sel_pipe[s][j] <= sel_pipe[s-1][j];
                    end
                end
            end
        end
    end

    assign rdvalid = vld_pipe[RD_LATENCY-1];

    always_comb begin
        rdselect = '0;
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            rdselect[SELECT_WIDTH*j +: SELECT_WIDTH] = sel_pipe[RD_LATENCY-1][j];
        end
    end

    // ------------------------------------------------------------------
    // Collision reporting
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrcollision     <= 1'b0;
            collision_count <= '0;
        end else begin
            wrcollision <= wcoll;
            if (cnt_clear) begin
                collision_count <= '0;
            end else if (wcoll && collision_count != '1) begin
                collision_count <= collision_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lvt_accounter.sv
// tb_lvt_accounter
//   Drives four lvt_accounter instances with shared stimulus:
//     a: defaults (latency 1, highest writer wins, old owner on RDW)
//     b: depth 200, latency 3, lowest writer wins, new owner on RDW, 2-bit count
//     c: latency 4, highest writer wins, new owner on RDW
//     d: single write agent, latency 1
//   A table of write/read vectors with hand-computed owners, then
//   hand-written sequences for read-during-write, counter clear/saturation
//   and reset with reads in flight.
module tb_lvt_accounter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int LAT_C = 4;
    localparam int LAT_D = 1;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  wren;
    logic [15:0] wraddr;
    logic [1:0]  rden;
    logic [15:0] rdaddr;
    logic        cnt_clear;

    logic [1:0]  sel_a, sel_b, sel_c, sel_d;
    logic [1:0]  vld_a, vld_b, vld_c, vld_d;
    logic        wrc_a, wrc_b, wrc_c, wrc_d;
    logic [15:0] cnt_a_o, cnt_c_o, cnt_d_o;
    logic [1:0]  cnt_b_o;

    int checks   = 0;
    int failures = 0;
    int cnt_a    = 0;
    int cnt_b    = 0;

    always #5 aclk = ~aclk;

    lvt_accounter #(.RD_LATENCY(LAT_A)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
        .rden(rden), .rdaddr(rdaddr), .cnt_clear(cnt_clear),
        .rdselect(sel_a), .rdvalid(vld_a), .wrcollision(wrc_a),
        .collision_count(cnt_a_o));

    lvt_accounter #(.RAM_DEPTH(200), .RD_LATENCY(LAT_B), .COLLISION_POLICY(1),
                    .RDW_MODE(1), .COUNT_WIDTH(2)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
        .rden(rden), .rdaddr(rdaddr), .cnt_clear(cnt_clear),
        .rdselect(sel_b), .rdvalid(vld_b), .wrcollision(wrc_b),
        .collision_count(cnt_b_o));

    lvt_accounter #(.RD_LATENCY(LAT_C), .RDW_MODE(1)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
        .rden(rden), .rdaddr(rdaddr), .cnt_clear(cnt_clear),
        .rdselect(sel_c), .rdvalid(vld_c), .wrcollision(wrc_c),
        .collision_count(cnt_c_o));

    lvt_accounter #(.NB_WRAGENT(1), .RD_LATENCY(LAT_D)) dut_d (
        .aclk(aclk), .aresetn(aresetn), .wren(wren[0:0]), .wraddr(wraddr[7:0]),
        .rden(rden), .rdaddr(rdaddr), .cnt_clear(cnt_clear),
        .rdselect(sel_d), .rdvalid(vld_d), .wrcollision(wrc_d),
        .collision_count(cnt_d_o));

    typedef struct {
        logic [1:0] we;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [1:0] ea;   // expected {agent1, agent0} select, policy 0, depth 256
        logic [1:0] eb;   // expected select for dut_b
        logic       ca;   // collision expected (depth 256)
        logic       cb;   // collision expected for dut_b
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h @%0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk(tag, "cnt_a", 32'(cnt_a_o), 32'(cnt_a));
        chk(tag, "cnt_b", 32'(cnt_b_o), 32'(cnt_b));
        chk(tag, "cnt_c", 32'(cnt_c_o), 32'(cnt_a));
        chk(tag, "cnt_d", 32'(cnt_d_o), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, "vld_a", 32'(vld_a), 0); chk(tag, "sel_a", 32'(sel_a), 0);
        chk(tag, "vld_b", 32'(vld_b), 0); chk(tag, "sel_b", 32'(sel_b), 0);
        chk(tag, "vld_c", 32'(vld_c), 0); chk(tag, "sel_c", 32'(sel_c), 0);
        chk(tag, "vld_d", 32'(vld_d), 0); chk(tag, "sel_d", 32'(sel_d), 0);
        chk(tag, "wrc_a", 32'(wrc_a), 0); chk(tag, "wrc_b", 32'(wrc_b), 0);
        chk(tag, "wrc_c", 32'(wrc_c), 0); chk(tag, "wrc_d", 32'(wrc_d), 0);
        chk(tag, "cnt_a", 32'(cnt_a_o), 0); chk(tag, "cnt_b", 32'(cnt_b_o), 0);
        chk(tag, "cnt_c", 32'(cnt_c_o), 0); chk(tag, "cnt_d", 32'(cnt_d_o), 0);
    endtask

    // Issues one read on the next edge (any wren set by the caller is applied
    // in the same cycle), then follows all four pipelines for five edges.
    task automatic read_check(input string tag, input logic [1:0] re,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic [1:0] ec);
        rden   = re;
        rdaddr = {r1, r0};
        @(posedge aclk); #1;
        wren = '0;
        rden = '0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                @(posedge aclk); #1;
            end
            if (k == 1) begin
                chk(tag, "wrc_a_drop", 32'(wrc_a), 0);
                chk(tag, "wrc_b_drop", 32'(wrc_b), 0);
                chk(tag, "wrc_c_drop", 32'(wrc_c), 0);
                chk(tag, "wrc_d_drop", 32'(wrc_d), 0);
            end
            chk(tag, "vld_a", 32'(vld_a), (k == LAT_A) ? 32'(re) : 0);
            chk(tag, "vld_b", 32'(vld_b), (k == LAT_B) ? 32'(re) : 0);
            chk(tag, "vld_c", 32'(vld_c), (k == LAT_C) ? 32'(re) : 0);
            chk(tag, "vld_d", 32'(vld_d), (k == LAT_D) ? 32'(re) : 0);
            if (k >= LAT_A) chk(tag, "sel_a", 32'(sel_a & re), 32'(ea & re));
            if (k >= LAT_B) chk(tag, "sel_b", 32'(sel_b & re), 32'(eb & re));
            if (k >= LAT_C) chk(tag, "sel_c", 32'(sel_c & re), 32'(ec & re));
            if (k >= LAT_D) chk(tag, "sel_d", 32'(sel_d & re), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //            we     w0     w1     r0     r1     ea     eb     ca    cb
        vecs[0] = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h05, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 8'h00, 8'h00, 8'hFF, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 8'h00, 8'h10, 8'h10, 8'h11, 2'b01, 2'b01, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 8'h10, 8'h20, 8'h10, 8'h20, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 8'h20, 8'h20, 8'h20, 8'h10, 2'b01, 2'b00, 1'b1, 1'b1};
        vecs[5] = '{2'b11, 8'h40, 8'h40, 8'h40, 8'h20, 2'b11, 2'b00, 1'b1, 1'b1};
        vecs[6] = '{2'b10, 8'h00, 8'hF0, 8'hF0, 8'hC7, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 8'hF8, 8'hF8, 8'hF8, 8'h40, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[8] = '{2'b01, 8'h40, 8'h00, 8'h40, 8'hF0, 2'b10, 2'b00, 1'b0, 1'b0};
        vecs[9] = '{2'b10, 8'h00, 8'hC7, 8'hC7, 8'hC8, 2'b01, 2'b01, 1'b0, 1'b0};

        aresetn   = 1'b0;
        wren      = '0;
        wraddr    = '0;
        rden      = '0;
        rdaddr    = '0;
        cnt_clear = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk_outputs_zero("reset");
        @(negedge aclk);
        aresetn = 1'b1;

        // Vector table: one write cycle, then a read of two rows
        foreach (vecs[n]) begin
            wren   = vecs[n].we;
            wraddr = {vecs[n].w1, vecs[n].w0};
            rden   = '0;
            @(posedge aclk); #1;
            wren = '0;
            if (vecs[n].ca) cnt_a++;
            if (vecs[n].cb && cnt_b < 3) cnt_b++;
            chk("vec_wr", "wrc_a", 32'(wrc_a), 32'(vecs[n].ca));
            chk("vec_wr", "wrc_b", 32'(wrc_b), 32'(vecs[n].cb));
            chk("vec_wr", "wrc_c", 32'(wrc_c), 32'(vecs[n].ca));
            chk("vec_wr", "wrc_d", 32'(wrc_d), 0);
            chk_counts("vec_wr");
            read_check("vec_rd", 2'b11, vecs[n].r0, vecs[n].r1,
                       vecs[n].ea, vecs[n].eb, vecs[n].ea);
        end

        // Read-during-write: agent 1 writes 0x30 while agent 0 reads it
        wren   = 2'b10;
        wraddr = {8'h30, 8'h00};
        read_check("rdw", 2'b01, 8'h30, 8'h00, 2'b00, 2'b01, 2'b01);
        read_check("rdw_after", 2'b11, 8'h30, 8'h30, 2'b11, 2'b11, 2'b11);

        // Clear concurrent with a collision: clear wins
        wren      = 2'b11;
        wraddr    = {8'h50, 8'h50};
        cnt_clear = 1'b1;
        @(posedge aclk); #1;
        cnt_clear = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        chk("clr", "wrc_a", 32'(wrc_a), 1);
        chk("clr", "wrc_b", 32'(wrc_b), 1);
        chk("clr", "wrc_c", 32'(wrc_c), 1);
        chk_counts("clr");

        // Five back-to-back collision cycles: dut_b saturates at 3
        for (int n = 0; n < 5; n++) begin
            @(posedge aclk); #1;
            cnt_a++;
            if (cnt_b < 3) cnt_b++;
            chk("sat", "wrc_a", 32'(wrc_a), 1);
            chk("sat", "wrc_b", 32'(wrc_b), 1);
            chk_counts("sat");
        end
        wren = '0;
        @(posedge aclk); #1;
        chk("sat_end", "wrc_a", 32'(wrc_a), 0);
        chk("sat_end", "wrc_b", 32'(wrc_b), 0);
        chk_counts("sat_end");

        // Reset with reads in flight
        rden   = 2'b11;
        rdaddr = {8'h30, 8'h30};
        @(posedge aclk); #1;
        rden = '0;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        cnt_a = 0;
        cnt_b = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge aclk); #1;
            chk("post_reset", "vld_a", 32'(vld_a), 0);
            chk("post_reset", "vld_b", 32'(vld_b), 0);
            chk("post_reset", "vld_c", 32'(vld_c), 0);
            chk("post_reset", "vld_d", 32'(vld_d), 0);
        end
        read_check("tbl_reset1", 2'b11, 8'h30, 8'h10, 2'b00, 2'b00, 2'b00);
        read_check("tbl_reset2", 2'b11, 8'hF0, 8'h20, 2'b00, 2'b00, 2'b00);
        chk_counts("tbl_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
